// File: rtl/sram_playback.sv
// Streams a 1-bit-per-pixel monochrome frame from an asynchronous SRAM onto a VGA-style raster.
// Frame base addresses advance frame by frame, wrap at LOOP_END, and can be redirected by a jump request.
module sram_playback #(
    parameter int          CLK_DIV  = 4,
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter logic [17:0] LOOP_END = 18'h3FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        play,
    input  logic        jump,
    input  logic [17:0] jump_addr,
    output logic [17:0] addr,
    inout  logic [7:0]  io,
    output logic        cs,
    output logic        we,
    output logic        oe,
    output logic        h_sync,
    output logic        v_sync,
    output logic [3:0]  r_out,
    output logic [3:0]  g_out,
    output logic [3:0]  b_out,
    output logic        frame_start
);

    localparam int FRAME_BYTES = H_ACTIVE * V_ACTIVE / 8;
    localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START    = H_ACTIVE + H_FP;
    localparam int HS_END      = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START    = V_ACTIVE + V_FP;
    localparam int VS_END      = V_ACTIVE + V_FP + V_SYNC;
    localparam int DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int H_W         = $clog2(H_TOTAL);
    localparam int V_W         = $clog2(V_TOTAL);

    typedef enum logic [1:0] {
        IDLE,
        PRELOAD,
        ACTIVE
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [H_W-1:0]   h_cnt_q, h_cnt_d;
    logic [V_W-1:0]   v_cnt_q, v_cnt_d;
    logic             h_sync_q, h_sync_d;
    logic             v_sync_q, v_sync_d;
    logic [1:0]       pre_cnt_q, pre_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       prefetch_q, prefetch_d;
    logic [17:0]      base_q, base_d;
    logic [17:0]      addr_q, addr_d;
    logic             jump_pend_q, jump_pend_d;
    logic [17:0]      jump_lat_q, jump_lat_d;
    logic             fresh_q, fresh_d;
    logic [3:0]       colour_q, colour_d;
    logic             frame_start_q, frame_start_d;

    logic             tick;
    logic             active;
    logic             boundary;
    logic             wrap_seq;
    logic [17:0]      seq_base;
    logic [17:0]      next_base;
    int               h_i;
    int               v_i;
    int               h_next_i;
    int               v_next_i;

    assign h_i      = int'(h_cnt_q);
    assign v_i      = int'(v_cnt_q);
    assign h_next_i = int'(h_cnt_d);
    assign v_next_i = int'(v_cnt_d);
    assign tick     = (div_q == DIV_W'(CLK_DIV - 1));
    assign active   = (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
    assign boundary = tick && play && (state_q == IDLE) && (h_i == 0) && (v_i == V_TOTAL - 1);

    // The next frame must fit entirely below LOOP_END, otherwise playback loops back to address 0.
    assign seq_base = base_q + 18'(FRAME_BYTES);
    assign wrap_seq = ({2'b00, base_q} + 20'(2 * FRAME_BYTES - 1)) > {2'b00, LOOP_END};

    always_comb begin
        if (jump) begin
            next_base = jump_addr;
        end else if (jump_pend_q) begin
            next_base = jump_lat_q;
        end else if (fresh_q || wrap_seq) begin
            next_base = '0;
        end else begin
            next_base = seq_base;
        end
    end

    always_comb begin
        state_d       = state_q;
        div_d         = tick ? '0 : div_q + 1'b1;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        pre_cnt_d     = pre_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        prefetch_d    = prefetch_q;
        base_d        = base_q;
        addr_d        = addr_q;
        jump_pend_d   = jump_pend_q;
        jump_lat_d    = jump_lat_q;
        fresh_d       = fresh_q;
        colour_d      = colour_q;
        frame_start_d = 1'b0;

        if (tick) begin
            if (h_i == H_TOTAL - 1) begin
                h_cnt_d = '0;
                v_cnt_d = (v_i == V_TOTAL - 1) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
            colour_d = '0;
            if (play && (state_q == ACTIVE) && active) begin
                colour_d = shift_q[7] ? 4'b0101 : 4'b0001;
            end
        end

        if (jump) begin
            jump_pend_d = 1'b1;
            jump_lat_d  = jump_addr;
        end

        if (tick && !play) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (boundary) begin
                        state_d       = PRELOAD;
                        addr_d        = next_base;
                        base_d        = next_base;
                        pre_cnt_d     = '0;
                        fresh_d       = 1'b0;
                        jump_pend_d   = 1'b0;
                        frame_start_d = 1'b1;
                    end
                end
                PRELOAD: begin
                    if (tick) begin
                        pre_cnt_d = pre_cnt_q + 1'b1;
                        if (pre_cnt_q == 2'd3) begin
                            shift_d   = io;
                            addr_d    = addr_q + 1'b1;
                            bit_cnt_d = '0;
                            state_d   = ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    // The following byte is fetched mid-byte so SRAM settling never lands on a reload tick.
                    if (tick && active) begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd3) begin
                            prefetch_d = io;
                        end
                        if (bit_cnt_q == 3'd7) begin
                            shift_d = prefetch_q;
                            addr_d  = addr_q + 1'b1;
                        end
                        if ((h_i == H_ACTIVE - 1) && (v_i == V_ACTIVE - 1)) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        h_sync_d = !((h_next_i >= HS_START) && (h_next_i < HS_END));
        v_sync_d = !((v_next_i >= VS_START) && (v_next_i < VS_END));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            div_q         <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            h_sync_q      <= 1'b1;
            v_sync_q      <= 1'b1;
            pre_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            prefetch_q    <= '0;
            base_q        <= '0;
            addr_q        <= '0;
            jump_pend_q   <= 1'b0;
            jump_lat_q    <= '0;
            fresh_q       <= 1'b1;
            colour_q      <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            pre_cnt_q     <= pre_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            prefetch_q    <= prefetch_d;
            base_q        <= base_d;
            addr_q        <= addr_d;
            jump_pend_q   <= jump_pend_d;
            jump_lat_q    <= jump_lat_d;
            fresh_q       <= fresh_d;
            colour_q      <= colour_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign addr        = addr_q;
    assign cs          = 1'b0;
    assign we          = 1'b1;
    assign oe          = !play;
    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign r_out       = colour_q;
    assign g_out       = colour_q;
    assign b_out       = colour_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sram_playback.sv
// Scoreboard bench for sram_playback on a shrunken raster: a reference model of the raster and frame
// addressing queues the expected colour of every pixel at frame start and compares on each pixel tick.
module tb_sram_playback;

    localparam int CD = 2;
    localparam int HA = 16;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 3;
    localparam int VA = 8;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FB = HA * VA / 8;
    localparam int LE = 47;
    localparam int FRAME_CLK = HT * VT * CD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        play;
    logic        jump;
    logic [17:0] jump_addr;
    logic [17:0] addr;
    wire  [7:0]  io;
    logic        cs;
    logic        we;
    logic        oe;
    logic        h_sync;
    logic        v_sync;
    logic [3:0]  r_out;
    logic [3:0]  g_out;
    logic [3:0]  b_out;
    logic        frame_start;

    int assertCount = 0;
    int failCount   = 0;

    // Asynchronous SRAM contents: the first frame is all 8'hA5, everything above it is address dependent.
    function automatic logic [7:0] memByte(input logic [17:0] a);
        if (a < 18'd16) return 8'hA5;
        return {a[3:0], a[7:4]} ^ a[15:8] ^ {a[17:16], 6'h2B};
    endfunction

    assign io = memByte(addr);

    always #5 clk = ~clk;

    sram_playback #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .LOOP_END(18'(LE))
    ) dut (
        .clk(clk), .rst_n(rst_n), .play(play), .jump(jump), .jump_addr(jump_addr),
        .addr(addr), .io(io), .cs(cs), .we(we), .oe(oe),
        .h_sync(h_sync), .v_sync(v_sync), .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .frame_start(frame_start)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic p, input logic j, input logic [17:0] ja);
        play      = p;
        jump      = j;
        jump_addr = ja;
        #1;
        checkOutput("oe", 32'(oe), 32'(!p));
    endtask

    // Reference model, evaluated on each rising edge from the inputs the DUT sees on that edge.
    int          edgeCnt = 0;
    bit          modelValid = 0;
    bit          tickNow = 0;
    bit          expFs = 0;
    bit          framePlaying = 0;
    bit          mFresh = 1;
    bit          mPend = 0;
    logic [17:0] mLat = '0;
    logic [17:0] mBase = '0;
    logic [17:0] expAddr = '0;
    logic [3:0]  expColour = '0;
    int          postH = 0;
    int          postV = 0;
    logic [3:0]  pixQ[$];

    always @(posedge clk) begin
        int          ticksDone;
        int          t;
        int          mH;
        int          mV;
        bit          boundaryNow;
        logic [17:0] nb;
        logic [7:0]  b;
        if (!rst_n) begin
            edgeCnt      = 0;
            modelValid   = 0;
            tickNow      = 0;
            expFs        = 0;
            framePlaying = 0;
            mFresh       = 1;
            mPend        = 0;
            mBase        = '0;
            pixQ.delete();
        end else begin
            edgeCnt++;
            modelValid  = 1;
            expFs       = 0;
            boundaryNow = 0;
            tickNow     = (edgeCnt % CD) == 0;
            ticksDone   = edgeCnt / CD;
            postH       = ticksDone % HT;
            postV       = (ticksDone / HT) % VT;
            if (tickNow) begin
                t  = ticksDone - 1;
                mH = t % HT;
                mV = (t / HT) % VT;
                expColour = 4'b0000;
                if (!play) begin
                    framePlaying = 0;
                    pixQ.delete();
                end else begin
                    if (framePlaying && mH < HA && mV < VA) begin
                        expColour = (pixQ.size() > 0) ? pixQ.pop_front() : 4'hE;
                        if (mH == HA - 1 && mV == VA - 1) framePlaying = 0;
                    end
                    if (!framePlaying && mH == 0 && mV == VT - 1) begin
                        if (jump)                           nb = jump_addr;
                        else if (mPend)                     nb = mLat;
                        else if (mFresh)                    nb = '0;
                        else if (int'(mBase) + 2*FB - 1 > LE) nb = '0;
                        else                                nb = mBase + 18'(FB);
                        mBase        = nb;
                        mFresh       = 0;
                        mPend        = 0;
                        expFs        = 1;
                        expAddr      = nb;
                        boundaryNow  = 1;
                        framePlaying = 1;
                        for (int k = 0; k < FB; k++) begin
                            b = memByte(nb + 18'(k));
                            for (int i = 7; i >= 0; i--) pixQ.push_back(b[i] ? 4'b0101 : 4'b0001);
                        end
                    end
                end
            end
            if (jump && !boundaryNow) begin
                mPend = 1;
                mLat  = jump_addr;
            end
        end
    end

    // Compare registered outputs half a cycle after each rising edge.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("frame_start", 32'(frame_start), 32'(expFs));
            if (expFs) checkOutput("frame_addr", 32'(addr), 32'(expAddr));
            if (tickNow) begin
                checkOutput("r_out", 32'(r_out), 32'(expColour));
                checkOutput("g_out", 32'(g_out), 32'(expColour));
                checkOutput("b_out", 32'(b_out), 32'(expColour));
                checkOutput("h_sync", 32'(h_sync), 32'(!(postH >= HA + HF && postH < HA + HF + HS)));
                checkOutput("v_sync", 32'(v_sync), 32'(!(postV >= VA + VF && postV < VA + VF + VS)));
            end
        end
    end

    // Park on the falling edge just before the tick that starts a frame boundary.
    task automatic waitBoundaryNext();
        int  e;
        int  t;
        bit  found;
        found = 0;
        for (int n = 0; n < 4 * FRAME_CLK && !found; n++) begin
            @(negedge clk);
            e = edgeCnt + 1;
            t = e / CD - 1;
            if ((e % CD) == 0 && (t % HT) == 0 && ((t / HT) % VT) == VT - 1) found = 1;
        end
        checkOutput("boundary_wait", 32'(found), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 18'h0);
        repeat (3) @(negedge clk);
        checkOutput("rst_h_sync", 32'(h_sync), 32'd1);
        checkOutput("rst_v_sync", 32'(v_sync), 32'd1);
        checkOutput("rst_colour", 32'({r_out, g_out, b_out}), 32'd0);
        checkOutput("rst_frame_start", 32'(frame_start), 32'd0);
        checkOutput("rst_addr", 32'(addr), 32'd0);
        checkOutput("cs", 32'(cs), 32'd0);
        checkOutput("we", 32'(we), 32'd1);
        rst_n = 1'b1;

        // Free run with playback disabled: sync only, colours dark.
        repeat (FRAME_CLK + 20) @(negedge clk);

        // Sequential frames, including the wrap back to address 0.
        applyStimulus(1'b1, 1'b0, 18'h0);
        repeat (4 * FRAME_CLK + 300) @(negedge clk);

        // Mid-frame jump takes effect only at the next boundary.
        applyStimulus(1'b1, 1'b1, 18'h20000);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 18'h0);
        repeat (FRAME_CLK + 100) @(negedge clk);

        // Two jumps before one boundary: the later one wins.
        applyStimulus(1'b1, 1'b1, 18'h00100);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 18'h0);
        repeat (20) @(negedge clk);
        applyStimulus(1'b1, 1'b1, 18'h00200);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 18'h0);
        repeat (FRAME_CLK) @(negedge clk);

        // A pending jump overridden by one arriving on the boundary clock itself.
        applyStimulus(1'b1, 1'b1, 18'h00400);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 18'h0);
        waitBoundaryNext();
        applyStimulus(1'b1, 1'b1, 18'h00300);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 18'h0);
        repeat (2 * FRAME_CLK) @(negedge clk);

        // Drop play part-way through the active area, restore it mid-frame.
        waitBoundaryNext();
        repeat (CD * HT * 5 + 7) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 18'h0);
        repeat (40) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 18'h0);
        repeat (2 * FRAME_CLK) @(negedge clk);

        // Reset mid-frame: playback restarts from address 0.
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst2_addr", 32'(addr), 32'd0);
        checkOutput("rst2_colour", 32'({r_out, g_out, b_out}), 32'd0);
        rst_n = 1'b1;
        repeat (2 * FRAME_CLK + 50) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
